// File: rtl/shift_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : shift_sequencer
// Purpose  : Multi-cycle 32-bit SLL/SRL/SRA/ROR unit that executes one
//            power-of-two stage (16, 8, 4, 2, 1) per RUN cycle.
// Revision : 1.0
// ============================================================================
module shift_sequencer #(
  parameter int SKIP_ZERO = 0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  input  logic [4:0]  in_shamt,
  input  logic [1:0]  in_op,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [1:0] c_OP_SLL = 2'd0;
  localparam logic [1:0] c_OP_SRL = 2'd1;
  localparam logic [1:0] c_OP_SRA = 2'd2;

  state_t      r_state;
  state_t      w_next;
  logic [31:0] r_data;
  logic [4:0]  r_shamt;
  logic [1:0]  r_op;
  logic        w_accept;
  logic        w_last;
  logic [2:0]  w_stage;
  logic [4:0]  w_amt;
  logic [31:0] w_shifted;

  function automatic logic [2:0] f_msb(input logic [4:0] m);
    f_msb = 3'd0;
    for (int i = 0; i < 5; i++) begin
      if (m[i]) f_msb = 3'(i);
    end
  endfunction

  assign w_accept = in_valid && (r_state == S_IDLE);

  // r_shamt loses each bit as its stage executes, so in skip mode the
  // highest remaining bit is always the next stage to visit.
  generate
    if (SKIP_ZERO != 0) begin : g_skip
      assign w_stage = f_msb(r_shamt);
      assign w_last  = ((r_shamt & ~(5'd1 << w_stage)) == 5'd0);
    end else begin : g_noskip
      logic [2:0] r_stage;
      always_ff @(posedge clock) begin
        if (reset) begin
          r_stage <= 3'd4;
        end else if (w_accept) begin
          r_stage <= 3'd4;
        end else if (r_state == S_RUN) begin
          r_stage <= r_stage - 3'd1;
        end
      end
      assign w_stage = r_stage;
      assign w_last  = (r_stage == 3'd0);
    end
  endgenerate

  assign w_amt = r_shamt[w_stage] ? (5'd1 << w_stage) : 5'd0;

  always_comb begin
    w_shifted = r_data;
    case (r_op)
      c_OP_SLL: w_shifted = r_data << w_amt;
      c_OP_SRL: w_shifted = r_data >> w_amt;
      c_OP_SRA: w_shifted = $signed(r_data) >>> w_amt;
      default:  w_shifted = (r_data >> w_amt) | (r_data << (6'd32 - {1'b0, w_amt}));
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    out_data  = 32'd0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_next = ((SKIP_ZERO != 0) && (in_shamt == 5'd0)) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        busy = 1'b1;
        if (w_last) w_next = S_DONE;
      end
      S_DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        out_data  = r_data;
        if (out_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_data  <= 32'd0;
      r_shamt <= 5'd0;
      r_op    <= 2'd0;
    end else if (w_accept) begin
      r_data  <= in_data;
      r_shamt <= in_shamt;
      r_op    <= in_op;
    end else if (r_state == S_RUN) begin
      r_data  <= w_shifted;
      r_shamt <= r_shamt & ~(5'd1 << w_stage);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_shift_sequencer.sv
`default_nettype none
// tb_shift_sequencer : directed vectors on both SKIP_ZERO variants, compared every
// cycle against a whole-shift reference model with latency counters.
module tb_shift_sequencer;

  logic clock = 1'b0;
  logic reset = 1'b1;

  logic        t_in_valid  [2];
  logic        t_in_ready  [2];
  logic [31:0] t_in_data   [2];
  logic [4:0]  t_in_shamt  [2];
  logic [1:0]  t_in_op     [2];
  logic        t_out_valid [2];
  logic        t_out_ready [2];
  logic [31:0] t_out_data  [2];
  logic        t_busy      [2];

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  always #5 clock = ~clock;

  shift_sequencer #(.SKIP_ZERO(0)) u_dut0 (
    .clock(clock), .reset(reset),
    .in_valid(t_in_valid[0]), .in_ready(t_in_ready[0]), .in_data(t_in_data[0]),
    .in_shamt(t_in_shamt[0]), .in_op(t_in_op[0]),
    .out_valid(t_out_valid[0]), .out_ready(t_out_ready[0]), .out_data(t_out_data[0]),
    .busy(t_busy[0])
  );

  shift_sequencer #(.SKIP_ZERO(1)) u_dut1 (
    .clock(clock), .reset(reset),
    .in_valid(t_in_valid[1]), .in_ready(t_in_ready[1]), .in_data(t_in_data[1]),
    .in_shamt(t_in_shamt[1]), .in_op(t_in_op[1]),
    .out_valid(t_out_valid[1]), .out_ready(t_out_ready[1]), .out_data(t_out_data[1]),
    .busy(t_busy[1])
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: whole shift in one step; timing as a plain countdown
  function automatic logic [31:0] ref_shift(input logic [1:0] op, input logic [31:0] d, input int s);
    case (op)
      2'd0:    return d << s;
      2'd1:    return d >> s;
      2'd2:    return 32'($signed(d) >>> s);
      default: return (s == 0) ? d : ((d >> s) | (d << (32 - s)));
    endcase
  endfunction

  int          m_st  [2] = '{0, 0};   // 0 idle, 1 working, 2 result shown
  int          m_cnt [2] = '{0, 0};
  logic [31:0] m_res [2];

  always @(posedge clock) begin
    for (int d = 0; d < 2; d++) begin
      if (reset) begin
        m_st[d] <= 0;
      end else begin
        case (m_st[d])
          0: if (t_in_valid[d]) begin
            m_res[d] <= ref_shift(t_in_op[d], t_in_data[d], int'(t_in_shamt[d]));
            m_cnt[d] <= (d == 1) ? $countones(t_in_shamt[d]) : 5;
            m_st[d]  <= ((d == 1) && (t_in_shamt[d] == 5'd0)) ? 2 : 1;
          end
          1: begin
            m_cnt[d] <= m_cnt[d] - 1;
            if (m_cnt[d] == 1) m_st[d] <= 2;
          end
          default: if (t_out_ready[d]) m_st[d] <= 0;
        endcase
      end
    end
  end

  always @(negedge clock) begin
    if (chk_en) begin
      for (int d = 0; d < 2; d++) begin
        check($sformatf("cyc_in_ready%0d", d),  32'(t_in_ready[d]),  32'(m_st[d] == 0));
        check($sformatf("cyc_out_valid%0d", d), 32'(t_out_valid[d]), 32'(m_st[d] == 2));
        check($sformatf("cyc_busy%0d", d),      32'(t_busy[d]),      32'(m_st[d] != 0));
        check($sformatf("cyc_out_data%0d", d),  t_out_data[d],       (m_st[d] == 2) ? m_res[d] : 32'd0);
      end
    end
  end

  task automatic run_op(input int d, input logic [1:0] op, input logic [31:0] data,
                        input logic [4:0] sh, input logic [31:0] exp_data,
                        input int exp_lat, input int hold);
    int k;
    logic [31:0] held;
    @(negedge clock);
    t_in_valid[d] = 1'b1;
    t_in_op[d]    = op;
    t_in_data[d]  = data;
    t_in_shamt[d] = sh;
    @(posedge clock);
    @(negedge clock);
    t_in_valid[d] = 1'b0;
    t_in_data[d]  = $urandom;
    t_in_shamt[d] = 5'($urandom);
    t_in_op[d]    = 2'($urandom);
    k = 0;
    while (!t_out_valid[d] && k < 20) begin
      @(negedge clock);
      k++;
    end
    check($sformatf("latency%0d", d), 32'(k), 32'(exp_lat));
    check($sformatf("data%0d", d), t_out_data[d], exp_data);
    check($sformatf("model%0d", d), m_res[d], exp_data);
    held = t_out_data[d];
    for (int i = 0; i < hold; i++) begin
      t_in_valid[d] = 1'b1;
      t_in_data[d]  = 32'hDEADBEEF;
      t_in_shamt[d] = 5'd3;
      @(negedge clock);
      check($sformatf("hold_data%0d", d), t_out_data[d], held);
      check($sformatf("hold_in_ready%0d", d), 32'(t_in_ready[d]), 32'd0);
    end
    t_in_valid[d]  = 1'b0;
    t_out_ready[d] = 1'b1;
    @(negedge clock);
    t_out_ready[d] = 1'b0;
    check($sformatf("consumed_valid%0d", d), 32'(t_out_valid[d]), 32'd0);
    check($sformatf("consumed_in_ready%0d", d), 32'(t_in_ready[d]), 32'd1);
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      t_in_valid[d]  = 1'b0;
      t_in_data[d]   = 32'd0;
      t_in_shamt[d]  = 5'd0;
      t_in_op[d]     = 2'd0;
      t_out_ready[d] = 1'b0;
    end
    repeat (2) @(negedge clock);
    chk_en = 1'b1;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("reset_in_ready%0d", d),  32'(t_in_ready[d]),  32'd1);
      check($sformatf("reset_out_valid%0d", d), 32'(t_out_valid[d]), 32'd0);
      check($sformatf("reset_busy%0d", d),      32'(t_busy[d]),      32'd0);
      check($sformatf("reset_out_data%0d", d),  t_out_data[d],       32'd0);
    end
    reset = 1'b0;

    // out_ready outside DONE must be ignored
    t_out_ready[0] = 1'b1;
    @(negedge clock);
    t_out_ready[0] = 1'b0;

    // fixed-latency variant
    run_op(0, 2'd2, 32'h80000000, 5'd16, 32'hFFFF8000, 5, 0);
    run_op(0, 2'd1, 32'h80000000, 5'd31, 32'h00000001, 5, 0);
    run_op(0, 2'd3, 32'h12345678, 5'd8,  32'h78123456, 5, 0);
    run_op(0, 2'd0, 32'h00000001, 5'd31, 32'h80000000, 5, 3);
    run_op(0, 2'd0, 32'h00000001, 5'd0,  32'h00000001, 5, 0);
    run_op(0, 2'd3, 32'h80000001, 5'd1,  32'hC0000000, 5, 0);

    // zero-skipping variant
    run_op(1, 2'd0, 32'h00000001, 5'd0,  32'h00000001, 0, 0);
    run_op(1, 2'd2, 32'hF0000000, 5'd5,  32'hFF800000, 2, 3);
    run_op(1, 2'd3, 32'h12345678, 5'd8,  32'h78123456, 1, 0);
    run_op(1, 2'd1, 32'h80000000, 5'd31, 32'h00000001, 5, 0);
    run_op(1, 2'd2, 32'h7FFFFFFF, 5'd30, 32'h00000001, 4, 0);

    // reset during the third RUN cycle abandons the operation
    @(negedge clock);
    t_in_valid[0] = 1'b1;
    t_in_op[0]    = 2'd2;
    t_in_data[0]  = 32'h80000000;
    t_in_shamt[0] = 5'd16;
    @(posedge clock);
    @(negedge clock);
    t_in_valid[0] = 1'b0;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("rst_run_out_valid", 32'(t_out_valid[0]), 32'd0);
    check("rst_run_busy",      32'(t_busy[0]),      32'd0);
    check("rst_run_in_ready",  32'(t_in_ready[0]),  32'd1);
    repeat (8) begin
      @(negedge clock);
      check("rst_run_no_result", 32'(t_out_valid[0]), 32'd0);
    end

    // reset while a result is waiting in DONE
    @(negedge clock);
    t_in_valid[1] = 1'b1;
    t_in_op[1]    = 2'd0;
    t_in_data[1]  = 32'h0000ABCD;
    t_in_shamt[1] = 5'd0;
    @(posedge clock);
    @(negedge clock);
    t_in_valid[1] = 1'b0;
    check("done_before_rst", 32'(t_out_valid[1]), 32'd1);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("rst_done_out_valid", 32'(t_out_valid[1]), 32'd0);
    check("rst_done_out_data",  t_out_data[1],       32'd0);
    check("rst_done_in_ready",  32'(t_in_ready[1]),  32'd1);
    repeat (4) @(negedge clock);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/shift_sequencer.md
SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

Interface
REQ-001 SHALL have parameter SKIP_ZERO, default 0, meaning 1 = skip shift stages whose shamt bit is 0.
REQ-002 SHALL have port clock, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1, synchronous and active-high.
REQ-004 SHALL have port in_valid, input, 1, request present.
REQ-005 SHALL have port in_ready, output, 1, request accepted when in_valid && in_ready at a clock edge.
REQ-006 SHALL have port in_data, input, 32, operand.
REQ-007 SHALL have port in_shamt, input, 5, shift amount 0..31.
REQ-008 SHALL have port in_op, input, 2, operation: 00 SLL, 01 SRL, 10 SRA, 11 ROR.
REQ-009 SHALL have port out_valid, output, 1, result present.
REQ-010 SHALL have port out_ready, input, 1, result consumed when out_valid && out_ready at a clock edge.
REQ-011 SHALL have port out_data, output, 32, result.
REQ-012 SHALL have port busy, output, 1, high in RUN or DONE.

Function
REQ-013 SHALL implement FSM states IDLE, RUN, DONE; in_ready = 1 only in IDLE; out_valid = 1 only in DONE.
REQ-014 On acceptance SHALL capture in_data, in_shamt and in_op; later input changes SHALL have no effect.
REQ-015 SHALL process one stage per RUN cycle, in order 16, 8, 4, 2, 1 (shamt bit 4 down to bit 0), with each stage shifting by 2^k when shamt[k] = 1 and passing through otherwise.
REQ-016 Stage fill rules SHALL be: SLL and SRL zero-fill; SRA fills with the operand's bit 31; ROR rotates vacated bits in from the opposite end.
REQ-017 With SKIP_ZERO = 0, IDLE→RUN SHALL occur at acceptance edge N, the last stage SHALL execute at edge N+5 (entering DONE), and out_valid SHALL first be high in the cycle after edge N+5, for every shamt including 0.
REQ-018 With SKIP_ZERO = 1, RUN SHALL visit only stages with shamt[k] = 1; out_valid SHALL first be high after edge N+popcount(shamt).
REQ-019 With SKIP_ZERO = 1 and shamt = 0, the block SHALL go IDLE→DONE at edge N with out_data = operand.
REQ-020 In DONE, out_data SHALL be held stable until out_ready is sampled high; at that edge the state SHALL go to IDLE.
REQ-021 Consumption and new acceptance SHALL NOT occur in the same cycle (in_ready = 0 in DONE).
REQ-022 out_ready while not in DONE SHALL be ignored.
REQ-023 in_valid while busy SHALL be ignored and SHALL not be queued.
REQ-024 out_data SHALL be 0 in every state other than DONE.

Reset
REQ-025 On reset the block SHALL enter IDLE; out_valid = 0, out_data = 0, busy = 0, in_ready = 1 in the following cycle.
REQ-026 Reset SHALL take priority over acceptance, stage execution and consumption.
REQ-027 Reset mid-RUN or in DONE SHALL abandon the operation with no result ever presented.

Verification
REQ-028 SRA, in_data 0x80000000, shamt 16, SKIP_ZERO 0 -> out_data 0xFFFF8000; out_valid first high 5 edges after acceptance.
REQ-029 SRL, 0x80000000, shamt 31 -> 0x00000001; ROR, 0x12345678, shamt 8 -> 0x78123456; SLL, 0x00000001, shamt 31 -> 0x80000000.
REQ-030 SLL, 0x00000001, shamt 0 -> with SKIP_ZERO 1, out_valid in the cycle right after acceptance, data 0x00000001; with SKIP_ZERO 0, 5-edge latency and the same data.
REQ-031 SKIP_ZERO 1, SRA, 0xF0000000, shamt 5 (0b00101) -> out_data 0xFF800000 after 2 RUN edges.
REQ-032 Hold out_ready low 3 cycles in DONE while driving a new in_valid -> out_data held stable, in_ready 0, new request dropped; out_ready high -> IDLE next cycle, in_ready 1.
REQ-033 Assert reset at the third RUN cycle -> next cycle out_valid 0, busy 0, in_ready 1, and no result emitted afterward.
